// File: rtl/isa_pkg.sv
// Shared sequencer ISA definitions: opcode field layout, opcode values and
// the fetch front-end state encoding.
package isa_pkg;
  localparam int OP_W    = 16;
  localparam int OPC_W   = 4;
  localparam int OPC_MSB = OP_W - 1;
  localparam int OPC_LSB = OP_W - OPC_W;

  typedef enum logic [OPC_W-1:0] {
    OPC_NOP  = 4'h0,
    OPC_LD   = 4'h1,
    OPC_ST   = 4'h2,
    OPC_ADD  = 4'h3,
    OPC_SUB  = 4'h4,
    OPC_CMP  = 4'h5,
    OPC_JMP  = 4'h8,
    OPC_JZ   = 4'h9,
    OPC_SET  = 4'hA,
    OPC_HALT = 4'hF
  } opc_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALTED,
    S_FAULT
  } fetch_state_e;
endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry FIFO of {op, pc} words feeding the decoder. Entry 0 is the head.
// The caller never pushes into a full FIFO nor pops an empty one.
module fetch_fifo2 #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]   cnt_q, cnt_d;

  // Next-state: flush beats everything, otherwise shift on pop and append on push
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_d = push_data;
          else               ent1_d = push_data;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_d = ent1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            ent0_d = push_data;
          end else begin
            ent0_d = ent1_q;
            ent1_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head  = ent0_q;
  assign count = cnt_q;
endmodule

// File: rtl/imem_fetch.sv
// Loadable instruction memory with a registered fetch front-end. Reads are
// synchronous; the read register acts as a bypass slot in front of the
// 2-entry FIFO so a fresh word reaches the decoder one cycle after issue.
module imem_fetch
  import isa_pkg::*;
#(
  parameter int               ADDR_W   = 8,
  parameter int               OP_W     = isa_pkg::OP_W,
  parameter int               DEPTH    = 256,
  parameter logic [OPC_W-1:0] HALT_OPC = OPC_HALT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [OP_W-1:0]   load_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [OP_W-1:0]   op,
  output logic [ADDR_W-1:0] op_pc,
  output logic              halted,
  output logic              fault
);
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              E_W     = OP_W + ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic              halted_q, halted_d, fault_q, fault_d;

  logic [OP_W-1:0]   mem [DEPTH];
  logic [OP_W-1:0]   rdata_q;
  logic [ADDR_W-1:0] rpc_q;

  logic              issue, mem_we, flush, push, pop, fifo_pop, halt_pop, head_valid;
  logic [E_W-1:0]    fifo_head, head;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occ;

  // Head selection, issue gating and control FSM next-state
  always_comb begin
    head_valid = (fifo_cnt != 2'd0) || inflight_q;
    head       = (fifo_cnt != 2'd0) ? fifo_head : {rdata_q, rpc_q};
    pop        = head_valid && op_ready;
    fifo_pop   = pop && (fifo_cnt != 2'd0);
    halt_pop   = pop && (state_q == S_FETCH) && (head[E_W-1 -: OPC_W] == HALT_OPC);
    // occupancy after this cycle's pop, counting the read landing now
    occ        = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    state_d    = state_q;
    pc_d       = pc_q;
    issue      = 1'b0;
    mem_we     = 1'b0;
    flush      = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (load_en) begin
          mem_we = ({1'b0, load_addr} < DEPTH_L);
        end else if (start) begin
          state_d = S_FETCH;
          pc_d    = start_pc;
        end
      end
      S_FETCH: begin
        if (halt_pop) begin
          state_d = S_HALTED;
          flush   = 1'b1;
        end else if (redir_valid) begin
          flush = 1'b1;
          pc_d  = redir_pc;
        end else if (occ < 3'd2) begin
          if ({1'b0, pc_q} < DEPTH_L) begin
            issue = 1'b1;
            pc_d  = pc_q + ADDR_W'(1);
          end else begin
            state_d = S_FAULT;
          end
        end
      end
      default: ;
    endcase
    inflight_d = issue;
    // a landing word popped straight from the bypass slot never enters the FIFO
    push       = inflight_q && !flush && !((fifo_cnt == 2'd0) && pop);
    halted_d   = (state_d == S_HALTED);
    fault_d    = (state_d == S_FAULT);
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      inflight_q <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  // Memory array and its read register; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[load_addr[IDX_W-1:0]] <= load_data;
    if (issue) begin
      rdata_q <= mem[pc_q[IDX_W-1:0]];
      rpc_q   <= pc_q;
    end
  end

  fetch_fifo2 #(.W(E_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({rdata_q, rpc_q}),
    .pop       (fifo_pop),
    .flush     (flush),
    .head      (fifo_head),
    .count     (fifo_cnt)
  );

  assign op_valid = head_valid;
  assign op       = head_valid ? head[E_W-1 -: OP_W] : '0;
  assign op_pc    = head_valid ? head[ADDR_W-1:0] : '0;
  assign halted   = halted_q;
  assign fault    = fault_q;
endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: directed program scenarios with literal expectations,
// a DEPTH=4 instance for the fault path, and randomized episodes checked
// every cycle against a stream-level reference model.
module tb_imem_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        load_en, start, redir_valid, op_ready;
  logic [7:0]  load_addr, start_pc, redir_pc;
  logic [15:0] load_data;
  logic        op_valid, halted, fault;
  logic [15:0] op;
  logic [7:0]  op_pc;

  logic        d4_load_en, d4_start, d4_redir, d4_op_ready;
  logic [7:0]  d4_load_addr, d4_start_pc, d4_redir_pc;
  logic [15:0] d4_load_data;
  logic        d4_op_valid, d4_halted, d4_fault;
  logic [15:0] d4_op;
  logic [7:0]  d4_op_pc;

  imem_fetch dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .start_pc(start_pc),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .op_valid(op_valid),
    .op_ready(op_ready), .op(op), .op_pc(op_pc), .halted(halted), .fault(fault)
  );

  imem_fetch #(.DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load_en(d4_load_en), .load_addr(d4_load_addr),
    .load_data(d4_load_data), .start(d4_start), .start_pc(d4_start_pc),
    .redir_valid(d4_redir), .redir_pc(d4_redir_pc), .op_valid(d4_op_valid),
    .op_ready(d4_op_ready), .op(d4_op), .op_pc(d4_op_pc), .halted(d4_halted), .fault(d4_fault)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (stream level) ----------------
  // The delivered stream must be mem[exp_pc], exp_pc advancing by one per
  // accepted word and jumping to the redirect target; start/redirect give
  // exactly one bubble cycle then a valid word; stalled words hold.
  logic [15:0] mem_m [256];
  int          m_st;          // 0 idle, 1 fetching, 2 halted
  logic [7:0]  exp_pc;
  int          since = 3;
  bit          stall_prev = 0;
  logic [15:0] prev_op;
  logic [7:0]  prev_pc;

  always @(negedge clk) begin
    logic [15:0] w;
    if (!rst_n) begin
      m_st = 0; since = 3; stall_prev = 0;
    end else begin
      chk("halted", 32'(halted), 32'(m_st == 2));
      chk("fault", 32'(fault), 32'(0));
      if (m_st != 1) chk("idle_valid", 32'(op_valid), 32'(0));
      if (since == 1) chk("lat_bubble", 32'(op_valid), 32'(0));
      if (since == 2) chk("lat_first", 32'(op_valid), 32'(1));
      if (stall_prev) begin
        chk("hold_valid", 32'(op_valid), 32'(1));
        chk("hold_op", 32'(op), 32'(prev_op));
        chk("hold_pc", 32'(op_pc), 32'(prev_pc));
      end
      if (op_valid) begin
        chk("stream_pc", 32'(op_pc), 32'(exp_pc));
        chk("stream_op", 32'(op), 32'(mem_m[exp_pc]));
      end
      stall_prev = 0;
      if (since < 3) since++;
      w = mem_m[exp_pc];
      case (m_st)
        0, 2: begin
          if (load_en) mem_m[load_addr] = load_data;
          else if (start) begin m_st = 1; exp_pc = start_pc; since = 1; end
        end
        1: begin
          if (op_valid && op_ready && w[15:12] == 4'hF) m_st = 2;
          else begin
            if (op_valid && op_ready) exp_pc++;
            if (redir_valid) begin exp_pc = redir_pc; since = 1; end
            else if (op_valid && !op_ready) begin
              stall_prev = 1; prev_op = op; prev_pc = op_pc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic quiet();
    load_en = 0; start = 0; redir_valid = 0; op_ready = 1;
    d4_load_en = 0; d4_start = 0; d4_redir = 0; d4_op_ready = 1;
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    load_en = 1; load_addr = a; load_data = d; nxt(); load_en = 0;
  endtask

  task automatic exp_op(input string nm, input bit v, input logic [15:0] o, input logic [7:0] p);
    smp();
    chk({nm, "_valid"}, 32'(op_valid), 32'(v));
    if (v) begin
      chk({nm, "_op"}, 32'(op), 32'(o));
      chk({nm, "_pc"}, 32'(op_pc), 32'(p));
    end
    nxt();
  endtask

  task automatic exp_d4(input string nm, input bit v, input logic [15:0] o, input logic [7:0] p, input bit f);
    smp();
    chk({nm, "_valid"}, 32'(d4_op_valid), 32'(v));
    chk({nm, "_fault"}, 32'(d4_fault), 32'(f));
    if (v) begin
      chk({nm, "_op"}, 32'(d4_op), 32'(o));
      chk({nm, "_pc"}, 32'(d4_op_pc), 32'(p));
    end
    nxt();
  endtask

  task automatic pulse_reset();
    quiet(); rst_n = 0; nxt(); nxt(); rst_n = 1; nxt();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [15:0] got [8];
  int          n;

  initial begin
    rst_n = 0; quiet();
    load_addr = 0; load_data = 0; start_pc = 0; redir_pc = 0;
    d4_load_addr = 0; d4_load_data = 0; d4_start_pc = 0; d4_redir_pc = 0;
    nxt(); nxt(); nxt();
    smp();
    chk("rst_valid", 32'(op_valid), 32'(0));
    chk("rst_op", 32'(op), 32'(0));
    chk("rst_pc", 32'(op_pc), 32'(0));
    chk("rst_halted", 32'(halted), 32'(0));
    chk("rst_fault", 32'(fault), 32'(0));
    nxt();
    rst_n = 1; nxt();

    // fill the whole memory so every fetch has a known value
    for (int a = 0; a < 256; a++) load(8'(a), 16'($urandom));

    // program run with op_ready=1
    load(8'd0, 16'hA000); load(8'd1, 16'hA001); load(8'd2, 16'hF000);
    start = 1; start_pc = 0; nxt(); start = 0;
    exp_op("t1_c1", 0, 0, 0);
    exp_op("t1_c2", 1, 16'hA000, 8'd0);
    exp_op("t1_c3", 1, 16'hA001, 8'd1);
    exp_op("t1_c4", 1, 16'hF000, 8'd2);
    smp(); chk("t1_halted", 32'(halted), 32'(1)); nxt();
    exp_op("t1_c6", 0, 0, 0);

    // ready toggling 1,0,0,1 with a load attempt while fetching
    start = 1; start_pc = 0; nxt(); start = 0;
    n = 0;
    for (int c = 0; c < 30 && !halted; c++) begin
      op_ready = ((c % 4) == 0) || ((c % 4) == 3);
      load_en = (c == 2); load_addr = 8'd1; load_data = 16'h1234;
      smp();
      if (op_valid && op_ready && n < 8) begin got[n] = op; n++; end
      nxt();
    end
    load_en = 0; op_ready = 1;
    chk("t2_count", 32'(n), 32'(3));
    chk("t2_op0", 32'(got[0]), 32'hA000);
    chk("t2_op1", 32'(got[1]), 32'hA001);
    chk("t2_op2", 32'(got[2]), 32'hF000);

    // read back: the load during fetch must not have landed
    start = 1; start_pc = 8'd1; nxt(); start = 0;
    exp_op("rb_c1", 0, 0, 0);
    exp_op("rb_c2", 1, 16'hA001, 8'd1);
    exp_op("rb_c3", 1, 16'hF000, 8'd2);
    nxt();

    // redirect while op@1 is popped
    load(8'd8, 16'hC008); load(8'd9, 16'hF000);
    start = 1; start_pc = 0; nxt(); start = 0;
    exp_op("rd_c1", 0, 0, 0);
    exp_op("rd_c2", 1, 16'hA000, 8'd0);
    redir_valid = 1; redir_pc = 8'd8;
    exp_op("rd_c3", 1, 16'hA001, 8'd1);
    redir_valid = 0;
    exp_op("rd_c4", 0, 0, 0);
    exp_op("rd_c5", 1, 16'hC008, 8'd8);
    exp_op("rd_c6", 1, 16'hF000, 8'd9);
    smp(); chk("rd_halted", 32'(halted), 32'(1)); nxt();

    // restart from HALTED at pc 5
    load(8'd5, 16'hB005); load(8'd6, 16'hF000);
    start = 1; start_pc = 8'd5; nxt(); start = 0;
    exp_op("r5_c1", 0, 0, 0);
    exp_op("r5_c2", 1, 16'hB005, 8'd5);
    exp_op("r5_c3", 1, 16'hF000, 8'd6);
    nxt();

    // DEPTH=4 instance: run off the end of memory
    for (int a = 0; a < 4; a++) begin
      d4_load_en = 1; d4_load_addr = 8'(a); d4_load_data = 16'h1110 + 16'(a); nxt();
    end
    d4_load_en = 0;
    for (int rep = 0; rep < 2; rep++) begin
      d4_start = 1; d4_start_pc = 8'd2; nxt(); d4_start = 0;
      exp_d4("f_c1", 0, 0, 0, 0);
      exp_d4("f_c2", 1, 16'h1112, 8'd2, 0);
      exp_d4("f_c3", 1, 16'h1113, 8'd3, 0);
      exp_d4("f_c4", 0, 0, 0, 1);
      exp_d4("f_c5", 0, 0, 0, 1);
      rst_n = 0; nxt();
      smp();
      chk("f_rst_valid", 32'(d4_op_valid), 32'(0));
      chk("f_rst_op", 32'(d4_op), 32'(0));
      chk("f_rst_pc", 32'(d4_op_pc), 32'(0));
      chk("f_rst_halted", 32'(d4_halted), 32'(0));
      chk("f_rst_fault", 32'(d4_fault), 32'(0));
      nxt(); rst_n = 1; nxt();
    end

    // randomized episodes, checked by the model every cycle
    for (int ep = 0; ep < 30; ep++) begin
      repeat ($urandom_range(0, 5)) begin
        load_en = 1; load_addr = 8'($urandom); load_data = 16'($urandom);
        start = ($urandom % 4) == 0; start_pc = 8'($urandom);
        nxt();
      end
      load_en = 0; start = 1; start_pc = 8'($urandom); nxt(); start = 0;
      for (int c = 0; c < 200; c++) begin
        op_ready = ($urandom % 4) != 0;
        redir_valid = ($urandom % 10) == 0; redir_pc = 8'($urandom);
        load_en = ($urandom % 8) == 0; load_addr = 8'($urandom); load_data = 16'($urandom);
        start = ($urandom % 16) == 0; start_pc = 8'($urandom);
        nxt();
        if (halted) break;
      end
      quiet();
      if (!halted) pulse_reset();
      nxt();
    end

    nxt(); nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
